// File: rtl/pipe_ctrl_if.sv
// Control-unit boundary: ID-stage instruction in, per-stage control bundles out.
// Handshake: id_valid qualifies id_instr for the current cycle; while stall=1
// the producer must present the same instruction again next cycle (PC and
// IF/ID hold), and hold=1 freezes every register regardless of id_valid.
interface pipe_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [31:0]       id_instr;
    logic              id_valid;
    logic              flush;
    logic              hold;
    logic              stall;
    logic [3:0]        ex_ctrl;
    logic [2:0]        ex_mem_ctrl;
    logic [1:0]        ex_wb_ctrl;
    logic [2:0]        mem_ctrl;
    logic [1:0]        mem_wb_ctrl;
    logic [1:0]        wb_ctrl;
    logic [REG_AW-1:0] wb_dest;
    logic              illegal;
    logic              illegal_sticky;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_instr, id_valid, flush, hold,
        input  stall, ex_ctrl, ex_mem_ctrl, ex_wb_ctrl, mem_ctrl, mem_wb_ctrl,
        input  wb_ctrl, wb_dest, illegal, illegal_sticky, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_instr, id_valid, flush, hold,
        output stall, ex_ctrl, ex_mem_ctrl, ex_wb_ctrl, mem_ctrl, mem_wb_ctrl,
        output wb_ctrl, wb_dest, illegal, illegal_sticky, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS main decoder: decodes the ID instruction and carries the
// EX/MEM/WB control bundles through ID/EX, EX/MEM and MEM/WB. Generates the
// load-use stall, applies branch flushes and global hold, and counts
// stall cycles and flush events with saturating counters.
module pipe_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int EN_IMM = 1,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Instruction fields
    logic [5:0]        id_op;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              unused_bits;

    assign id_op       = bus.id_instr[31:26];
    assign id_rs       = REG_AW'(bus.id_instr[25:21]);
    assign id_rt       = REG_AW'(bus.id_instr[20:16]);
    assign id_rd       = REG_AW'(bus.id_instr[15:11]);
    assign unused_bits = ^bus.id_instr[10:0];

    // Decode results
    logic [3:0]        dec_ex;
    logic [2:0]        dec_mem;
    logic [1:0]        dec_wb;
    logic [REG_AW-1:0] dec_dest;
    logic              dec_ill;
    logic              dec_reads_rt;

    // Hazard
    logic load_use;
    logic stall_int;

    // ID/EX
    logic [3:0]        ex_ctrl_q,  ex_ctrl_d;
    logic [2:0]        ex_mem_q,   ex_mem_d;
    logic [1:0]        ex_wb_q,    ex_wb_d;
    logic [REG_AW-1:0] ex_dest_q,  ex_dest_d;
    logic              ex_ill_q,   ex_ill_d;
    // EX/MEM
    logic [2:0]        mem_ctrl_q, mem_ctrl_d;
    logic [1:0]        mem_wb_q,   mem_wb_d;
    logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
    // MEM/WB
    logic [1:0]        wb_ctrl_q,  wb_ctrl_d;
    logic [REG_AW-1:0] wb_dest_q,  wb_dest_d;
    // Status
    logic              sticky_q,   sticky_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Main decode: opcode to {ex, mem, wb} bundles, destination and rt usage
    always_comb begin
        dec_ex       = 4'b0000;
        dec_mem      = 3'b000;
        dec_wb       = 2'b00;
        dec_dest     = '0;
        dec_ill      = 1'b0;
        dec_reads_rt = 1'b0;
        if (bus.id_valid) begin
            case (id_op)
                OP_RTYPE: begin
                    dec_ex       = 4'b1100;
                    dec_wb       = 2'b10;
                    dec_dest     = id_rd;
                    dec_reads_rt = 1'b1;
                end
                OP_LW: begin
                    dec_ex   = 4'b0001;
                    dec_mem  = 3'b010;
                    dec_wb   = 2'b11;
                    dec_dest = id_rt;
                end
                OP_SW: begin
                    dec_ex       = 4'b0001;
                    dec_mem      = 3'b001;
                    dec_reads_rt = 1'b1;
                end
                OP_BEQ: begin
                    dec_ex       = 4'b0010;
                    dec_mem      = 3'b100;
                    dec_reads_rt = 1'b1;
                end
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    if (EN_IMM != 0) begin
                        dec_ex   = 4'b0111;
                        dec_wb   = 2'b10;
                        dec_dest = id_rt;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                default: dec_ill = 1'b1;
            endcase
            // Writing $0 is a no-op, so never raise reg_write for it
            if (dec_dest == '0) begin
                dec_wb[1] = 1'b0;
            end
        end
    end

    // Load-use detection against the load sitting in ID/EX; flush/hold win
    always_comb begin
        load_use = 1'b0;
        if (bus.id_valid && ex_mem_q[1] && (ex_dest_q != '0)) begin
            if (ex_dest_q == id_rs) begin
                load_use = 1'b1;
            end else if (dec_reads_rt && (ex_dest_q == id_rt)) begin
                load_use = 1'b1;
            end
        end
        stall_int = load_use & ~bus.flush & ~bus.hold;
    end

    // Stage-register next state: hold > flush > stall > advance
    always_comb begin
        ex_ctrl_d   = ex_ctrl_q;
        ex_mem_d    = ex_mem_q;
        ex_wb_d     = ex_wb_q;
        ex_dest_d   = ex_dest_q;
        ex_ill_d    = ex_ill_q;
        mem_ctrl_d  = mem_ctrl_q;
        mem_wb_d    = mem_wb_q;
        mem_dest_d  = mem_dest_q;
        wb_ctrl_d   = wb_ctrl_q;
        wb_dest_d   = wb_dest_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.hold) begin
            if (bus.flush) begin
                ex_ctrl_d  = 4'b0000;
                ex_mem_d   = 3'b000;
                ex_wb_d    = 2'b00;
                ex_dest_d  = '0;
                ex_ill_d   = 1'b0;
                mem_ctrl_d = 3'b000;
                mem_wb_d   = 2'b00;
                mem_dest_d = '0;
                wb_ctrl_d  = mem_wb_q;
                wb_dest_d  = mem_dest_q;
                if (flush_cnt_q != CNT_MAX) begin
                    flush_cnt_d = flush_cnt_q + CNT_ONE;
                end
            end else begin
                mem_ctrl_d = ex_mem_q;
                mem_wb_d   = ex_wb_q;
                mem_dest_d = ex_dest_q;
                wb_ctrl_d  = mem_wb_q;
                wb_dest_d  = mem_dest_q;
                if (stall_int) begin
                    ex_ctrl_d = 4'b0000;
                    ex_mem_d  = 3'b000;
                    ex_wb_d   = 2'b00;
                    ex_dest_d = '0;
                    ex_ill_d  = 1'b0;
                    if (stall_cnt_q != CNT_MAX) begin
                        stall_cnt_d = stall_cnt_q + CNT_ONE;
                    end
                end else begin
                    ex_ctrl_d = dec_ex;
                    ex_mem_d  = dec_mem;
                    ex_wb_d   = dec_wb;
                    ex_dest_d = dec_dest;
                    ex_ill_d  = dec_ill;
                end
            end
        end
        sticky_d = sticky_q | ex_ill_d;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q   <= '0;
            ex_mem_q    <= '0;
            ex_wb_q     <= '0;
            ex_dest_q   <= '0;
            ex_ill_q    <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_wb_q    <= '0;
            mem_dest_q  <= '0;
            wb_ctrl_q   <= '0;
            wb_dest_q   <= '0;
            sticky_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            ex_mem_q    <= ex_mem_d;
            ex_wb_q     <= ex_wb_d;
            ex_dest_q   <= ex_dest_d;
            ex_ill_q    <= ex_ill_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_wb_q    <= mem_wb_d;
            mem_dest_q  <= mem_dest_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_dest_q   <= wb_dest_d;
            sticky_q    <= sticky_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall          = stall_int;
    assign bus.ex_ctrl        = ex_ctrl_q;
    assign bus.ex_mem_ctrl    = ex_mem_q;
    assign bus.ex_wb_ctrl     = ex_wb_q;
    assign bus.mem_ctrl       = mem_ctrl_q;
    assign bus.mem_wb_ctrl    = mem_wb_q;
    assign bus.wb_ctrl        = wb_ctrl_q;
    assign bus.wb_dest        = wb_dest_q;
    assign bus.illegal        = ex_ill_q;
    assign bus.illegal_sticky = sticky_q;
    assign bus.stall_cnt      = stall_cnt_q;
    assign bus.flush_cnt      = flush_cnt_q;
endmodule
